// File: rtl/sodor_mem_arbiter.sv
// Two-port (imem/dmem) arbiter onto a single memory port, one request outstanding at a time.
// Build option: define SODOR_ARB_RR_EN for round-robin arbitration; default is fixed dmem-over-imem priority.
//
// state | meaning
// IDLE  | arbitrating; winner's request driven to memory, granted when io_mem_req_ready=1
// WAIT  | one request outstanding; waiting for a response or for the wait counter to expire
module sodor_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        io_imem_req_valid,
  output logic        io_imem_req_ready,
  input  logic [31:0] io_imem_req_bits_addr,
  input  logic [31:0] io_imem_req_bits_data,
  input  logic        io_imem_req_bits_fcn,
  input  logic [2:0]  io_imem_req_bits_typ,
  output logic        io_imem_resp_valid,
  output logic [31:0] io_imem_resp_bits_data,

  input  logic        io_dmem_req_valid,
  output logic        io_dmem_req_ready,
  input  logic [31:0] io_dmem_req_bits_addr,
  input  logic [31:0] io_dmem_req_bits_data,
  input  logic        io_dmem_req_bits_fcn,
  input  logic [2:0]  io_dmem_req_bits_typ,
  output logic        io_dmem_resp_valid,
  output logic [31:0] io_dmem_resp_bits_data,

  output logic        io_mem_req_valid,
  input  logic        io_mem_req_ready,
  output logic [31:0] io_mem_req_bits_addr,
  output logic [31:0] io_mem_req_bits_data,
  output logic        io_mem_req_bits_fcn,
  output logic [2:0]  io_mem_req_bits_typ,
  input  logic        io_mem_resp_valid,
  input  logic [31:0] io_mem_resp_bits_data,

  output logic        io_busy,
  output logic        io_timeout
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_owner;       // 0 = imem, 1 = dmem
  logic [7:0]  r_cnt;
  logic        w_pick_dmem;
  logic        w_any_valid;
  logic        w_accept;
  logic        w_resp;
  logic        w_expire;
  logic [8:0]  w_cnt_inc;

  assign w_any_valid = io_imem_req_valid | io_dmem_req_valid;
  assign w_accept    = (r_state == S_IDLE) & w_any_valid & io_mem_req_ready;
  assign w_resp      = (r_state == S_WAIT) & io_mem_resp_valid;
  assign w_cnt_inc   = {1'b0, r_cnt} + 9'd1;
  // A response in the expiry cycle wins over the timeout.
  assign w_expire    = (r_state == S_WAIT) & ~io_mem_resp_valid & (w_cnt_inc == 9'(TIMEOUT));

`ifdef SODOR_ARB_RR_EN
  logic r_rr_ptr;             // 1 = dmem preferred on conflict

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rr_ptr <= 1'b0;
    end else if (w_accept) begin
      r_rr_ptr <= ~w_pick_dmem;
    end
  end

  assign w_pick_dmem = io_dmem_req_valid & (~io_imem_req_valid | r_rr_ptr);
`else
  assign w_pick_dmem = io_dmem_req_valid;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_WAIT;
      S_WAIT: if (w_resp || w_expire) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_owner <= 1'b0;
      r_cnt   <= 8'd0;
    end else if (w_accept) begin
      r_owner <= w_pick_dmem;
      r_cnt   <= 8'd0;
    end else if ((r_state == S_WAIT) && !w_resp && !w_expire) begin
      r_cnt   <= w_cnt_inc[7:0];
    end else begin
      r_cnt   <= 8'd0;
    end
  end

  always_comb begin
    io_mem_req_valid       = (r_state == S_IDLE) & w_any_valid;
    io_mem_req_bits_addr   = w_pick_dmem ? io_dmem_req_bits_addr : io_imem_req_bits_addr;
    io_mem_req_bits_data   = w_pick_dmem ? io_dmem_req_bits_data : io_imem_req_bits_data;
    io_mem_req_bits_fcn    = w_pick_dmem ? io_dmem_req_bits_fcn  : io_imem_req_bits_fcn;
    io_mem_req_bits_typ    = w_pick_dmem ? io_dmem_req_bits_typ  : io_imem_req_bits_typ;
    io_imem_req_ready      = w_accept & ~w_pick_dmem;
    io_dmem_req_ready      = w_accept &  w_pick_dmem;
    io_imem_resp_valid     = w_resp & ~r_owner;
    io_dmem_resp_valid     = w_resp &  r_owner;
    io_imem_resp_bits_data = io_mem_resp_bits_data;
    io_dmem_resp_bits_data = io_mem_resp_bits_data;
    io_busy                = (r_state == S_WAIT);
    io_timeout             = w_expire;
  end

endmodule

// File: tb/tb_sodor_mem_arbiter.sv
// Self-checking bench for sodor_mem_arbiter: expected responses are queued when stimulus is
// driven and popped by a monitor when either port raises resp_valid.
module tb_sodor_mem_arbiter;

  localparam int TMO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_imem_req_valid = 1'b0, io_dmem_req_valid = 1'b0;
  logic [31:0] io_imem_req_bits_addr = '0, io_imem_req_bits_data = '0;
  logic [31:0] io_dmem_req_bits_addr = '0, io_dmem_req_bits_data = '0;
  logic        io_imem_req_bits_fcn = 1'b0, io_dmem_req_bits_fcn = 1'b0;
  logic [2:0]  io_imem_req_bits_typ = '0, io_dmem_req_bits_typ = '0;
  logic        io_mem_req_ready = 1'b0;
  logic        io_mem_resp_valid = 1'b0;
  logic [31:0] io_mem_resp_bits_data = '0;

  logic        io_imem_req_ready, io_dmem_req_ready;
  logic        io_imem_resp_valid, io_dmem_resp_valid;
  logic [31:0] io_imem_resp_bits_data, io_dmem_resp_bits_data;
  logic        io_mem_req_valid;
  logic [31:0] io_mem_req_bits_addr, io_mem_req_bits_data;
  logic        io_mem_req_bits_fcn;
  logic [2:0]  io_mem_req_bits_typ;
  logic        io_busy, io_timeout;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        port;   // 0 = imem, 1 = dmem
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  sodor_mem_arbiter #(.TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .io_imem_req_valid(io_imem_req_valid), .io_imem_req_ready(io_imem_req_ready),
    .io_imem_req_bits_addr(io_imem_req_bits_addr), .io_imem_req_bits_data(io_imem_req_bits_data),
    .io_imem_req_bits_fcn(io_imem_req_bits_fcn), .io_imem_req_bits_typ(io_imem_req_bits_typ),
    .io_imem_resp_valid(io_imem_resp_valid), .io_imem_resp_bits_data(io_imem_resp_bits_data),
    .io_dmem_req_valid(io_dmem_req_valid), .io_dmem_req_ready(io_dmem_req_ready),
    .io_dmem_req_bits_addr(io_dmem_req_bits_addr), .io_dmem_req_bits_data(io_dmem_req_bits_data),
    .io_dmem_req_bits_fcn(io_dmem_req_bits_fcn), .io_dmem_req_bits_typ(io_dmem_req_bits_typ),
    .io_dmem_resp_valid(io_dmem_resp_valid), .io_dmem_resp_bits_data(io_dmem_resp_bits_data),
    .io_mem_req_valid(io_mem_req_valid), .io_mem_req_ready(io_mem_req_ready),
    .io_mem_req_bits_addr(io_mem_req_bits_addr), .io_mem_req_bits_data(io_mem_req_bits_data),
    .io_mem_req_bits_fcn(io_mem_req_bits_fcn), .io_mem_req_bits_typ(io_mem_req_bits_typ),
    .io_mem_resp_valid(io_mem_resp_valid), .io_mem_resp_bits_data(io_mem_resp_bits_data),
    .io_busy(io_busy), .io_timeout(io_timeout)
  );

  always #5 clock = ~clock;

  // Response monitor / scoreboard
  always @(negedge clock) begin
    if (io_imem_resp_valid || io_dmem_resp_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: imem_v=%0b dmem_v=%0b, required no response",
                 io_imem_resp_valid, io_dmem_resp_valid);
      end else begin
        mon_e = sb.pop_front();
        if ({io_imem_resp_valid, io_dmem_resp_valid} !== (mon_e.port ? 2'b01 : 2'b10) ||
            (mon_e.port ? io_dmem_resp_bits_data : io_imem_resp_bits_data) !== mon_e.data) begin
          errors++;
          $display("FAIL resp_route: imem_v=%0b dmem_v=%0b data=%08h, required port=%0d data=%08h",
                   io_imem_resp_valid, io_dmem_resp_valid,
                   mon_e.port ? io_dmem_resp_bits_data : io_imem_resp_bits_data,
                   mon_e.port, mon_e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    io_imem_req_valid = 1'b0;
    io_dmem_req_valid = 1'b0;
    io_mem_req_ready  = 1'b0;
    io_mem_resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++;
    if ({io_busy, io_timeout, io_mem_req_valid, io_imem_req_ready, io_dmem_req_ready,
         io_imem_resp_valid, io_dmem_resp_valid} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%0b tmo=%0b mreq=%0b ir=%0b dr=%0b iv=%0b dv=%0b, required all 0",
               io_busy, io_timeout, io_mem_req_valid, io_imem_req_ready, io_dmem_req_ready,
               io_imem_resp_valid, io_dmem_resp_valid);
    end
    #1 reset = 1'b1;
  endtask

  task automatic test_single_fetch();
    tick();
    io_imem_req_valid = 1'b1;
    io_imem_req_bits_addr = 32'h8000_0010;
    io_imem_req_bits_typ = 3'd2;
    io_mem_req_ready = 1'b1;
    @(negedge clock);
    checks++;
    if ({io_imem_req_ready, io_dmem_req_ready, io_mem_req_valid} !== 3'b101) begin
      errors++;
      $display("FAIL fetch_grant: ir/dr/mreq=%03b, required 101",
               {io_imem_req_ready, io_dmem_req_ready, io_mem_req_valid});
    end
    checks++;
    if (io_mem_req_bits_addr !== 32'h8000_0010) begin
      errors++;
      $display("FAIL fetch_addr: got %08h, required 80000010", io_mem_req_bits_addr);
    end
    tick();
    io_imem_req_valid = 1'b0;
    @(negedge clock);
    checks++;
    if ({io_busy, io_mem_req_valid} !== 2'b10) begin
      errors++;
      $display("FAIL fetch_wait1: busy/mreq=%02b, required 10", {io_busy, io_mem_req_valid});
    end
    tick();
    io_mem_resp_valid = 1'b1;
    io_mem_resp_bits_data = 32'h0000_0013;
    sb.push_back('{port: 1'b0, data: 32'h0000_0013});
    @(negedge clock);
    checks++;
    if (io_busy !== 1'b1) begin
      errors++;
      $display("FAIL fetch_wait2: busy=%0b, required 1", io_busy);
    end
    checks++;
    if (io_dmem_resp_bits_data !== 32'h0000_0013) begin
      errors++;
      $display("FAIL resp_data_passthru: got %08h, required 00000013", io_dmem_resp_bits_data);
    end
    tick();
    io_mem_resp_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (io_busy !== 1'b0) begin
      errors++;
      $display("FAIL fetch_done: busy=%0b, required 0", io_busy);
    end
  endtask

  task automatic test_conflict();
    logic       first;
    logic [2:0] seq;
`ifdef SODOR_ARB_RR_EN
    first = 1'b0;
    seq   = 3'b010;
`else
    first = 1'b1;
    seq   = 3'b111;
`endif
    tick();
    clear_inputs();
    reset = 1'b0;
    #2 reset = 1'b1;
    tick();
    io_imem_req_valid = 1'b1; io_imem_req_bits_addr = 32'h0000_1000; io_imem_req_bits_fcn = 1'b0;
    io_dmem_req_valid = 1'b1; io_dmem_req_bits_addr = 32'h0000_2000; io_dmem_req_bits_fcn = 1'b1;
    io_dmem_req_bits_data = 32'hDEAD_BEEF;
    io_mem_req_ready = 1'b1;
    @(negedge clock);
    checks++;
    if ({io_imem_req_ready, io_dmem_req_ready} !== {~first, first} ||
        io_mem_req_bits_addr !== (first ? 32'h0000_2000 : 32'h0000_1000) ||
        io_mem_req_bits_fcn !== first) begin
      errors++;
      $display("FAIL conflict_first: ir/dr=%02b addr=%08h fcn=%0b, required winner=%0d",
               {io_imem_req_ready, io_dmem_req_ready}, io_mem_req_bits_addr, io_mem_req_bits_fcn, first);
    end
    tick();
    if (first) io_dmem_req_valid = 1'b0; else io_imem_req_valid = 1'b0;
    io_mem_resp_valid = 1'b1; io_mem_resp_bits_data = 32'h0000_00A1;
    sb.push_back('{port: first, data: 32'h0000_00A1});
    @(negedge clock);
    checks++;
    if ({io_imem_req_ready, io_dmem_req_ready, io_mem_req_valid, io_busy} !== 4'b0001) begin
      errors++;
      $display("FAIL conflict_wait: ir/dr/mreq/busy=%04b, required 0001",
               {io_imem_req_ready, io_dmem_req_ready, io_mem_req_valid, io_busy});
    end
    tick();
    io_mem_resp_valid = 1'b0;
    @(negedge clock);
    checks++;
    if ({io_imem_req_ready, io_dmem_req_ready} !== {first, ~first}) begin
      errors++;
      $display("FAIL conflict_second: ir/dr=%02b, required winner=%0d",
               {io_imem_req_ready, io_dmem_req_ready}, ~first);
    end
    tick();
    if (first) io_imem_req_valid = 1'b0; else io_dmem_req_valid = 1'b0;
    io_mem_resp_valid = 1'b1; io_mem_resp_bits_data = 32'h0000_00A2;
    sb.push_back('{port: ~first, data: 32'h0000_00A2});
    @(negedge clock);
    tick();
    io_mem_resp_valid = 1'b0;
    io_imem_req_valid = 1'b1;
    io_dmem_req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++;
      if ({io_imem_req_ready, io_dmem_req_ready} !== {~seq[2-k], seq[2-k]}) begin
        errors++;
        $display("FAIL b2b_grant%0d: ir/dr=%02b, required winner=%0d",
                 k, {io_imem_req_ready, io_dmem_req_ready}, seq[2-k]);
      end
      tick();
      io_mem_resp_valid = 1'b1; io_mem_resp_bits_data = 32'h0000_00B0 + k;
      sb.push_back('{port: seq[2-k], data: 32'h0000_00B0 + k});
      @(negedge clock);
      checks++;
      if ({io_imem_req_ready, io_dmem_req_ready, io_busy} !== 3'b001) begin
        errors++;
        $display("FAIL b2b_wait%0d: ir/dr/busy=%03b, required 001",
                 k, {io_imem_req_ready, io_dmem_req_ready, io_busy});
      end
      tick();
      io_mem_resp_valid = 1'b0;
    end
    io_imem_req_valid = 1'b0;
    io_dmem_req_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_backpressure();
    tick();
    io_dmem_req_valid = 1'b1; io_dmem_req_bits_addr = 32'h0000_3000;
    io_mem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if ({io_dmem_req_ready, io_busy, io_mem_req_valid} !== 3'b001) begin
        errors++;
        $display("FAIL backpressure%0d: dr/busy/mreq=%03b, required 001",
                 i, {io_dmem_req_ready, io_busy, io_mem_req_valid});
      end
      tick();
    end
    io_mem_req_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (io_dmem_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: dr=%0b, required 1", io_dmem_req_ready);
    end
    tick();
    io_dmem_req_valid = 1'b0;
    io_mem_resp_valid = 1'b1; io_mem_resp_bits_data = 32'h0000_00C0;
    sb.push_back('{port: 1'b1, data: 32'h0000_00C0});
    @(negedge clock);
    tick();
    io_mem_resp_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_timeout();
    tick();
    io_imem_req_valid = 1'b1; io_imem_req_bits_addr = 32'h0000_4000;
    io_mem_req_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (io_imem_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL tmo_grant: ir=%0b, required 1", io_imem_req_ready);
    end
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) io_imem_req_valid = 1'b0;
      if (c == 5) begin
        io_mem_resp_valid = 1'b1; io_mem_resp_bits_data = 32'h0000_00DD;
      end
      @(negedge clock);
      checks++;
      if ({io_timeout, io_busy} !== {(c == TMO), (c <= TMO)}) begin
        errors++;
        $display("FAIL tmo_cycle%0d: timeout/busy=%02b, required %0b%0b",
                 c, {io_timeout, io_busy}, (c == TMO), (c <= TMO));
      end
      if (c == 5) begin
        checks++;
        if ({io_imem_resp_valid, io_dmem_resp_valid} !== 2'b00) begin
          errors++;
          $display("FAIL tmo_late_resp: iv/dv=%02b, required 00",
                   {io_imem_resp_valid, io_dmem_resp_valid});
        end
      end
    end
    tick();
    io_mem_resp_valid = 1'b0;
    io_imem_req_valid = 1'b1;
    @(negedge clock);
    for (int c = 1; c <= TMO; c++) begin
      tick();
      if (c == 1) io_imem_req_valid = 1'b0;
      if (c == TMO) begin
        io_mem_resp_valid = 1'b1; io_mem_resp_bits_data = 32'h0000_00EE;
        sb.push_back('{port: 1'b0, data: 32'h0000_00EE});
      end
      @(negedge clock);
      checks++;
      if (io_timeout !== 1'b0) begin
        errors++;
        $display("FAIL tmo_resp_wins%0d: timeout=%0b, required 0", c, io_timeout);
      end
    end
    tick();
    io_mem_resp_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (io_busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_resp_idle: busy=%0b, required 0", io_busy);
    end
  endtask

  task automatic test_reset_mid_wait();
    tick();
    io_dmem_req_valid = 1'b1; io_dmem_req_bits_addr = 32'h0000_5000;
    io_mem_req_ready = 1'b1;
    @(negedge clock);
    tick();
    io_dmem_req_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (io_busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_busy: busy=%0b, required 1", io_busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({io_busy, io_timeout} !== 2'b00) begin
      errors++;
      $display("FAIL rst_async: busy/timeout=%02b, required 00", {io_busy, io_timeout});
    end
    @(posedge clock);
    #2 reset = 1'b1;
    tick();
    io_mem_resp_valid = 1'b1; io_mem_resp_bits_data = 32'h0000_0BAD;
    @(negedge clock);
    checks++;
    if ({io_imem_resp_valid, io_dmem_resp_valid, io_busy} !== 3'b000) begin
      errors++;
      $display("FAIL rst_stray_resp: iv/dv/busy=%03b, required 000",
               {io_imem_resp_valid, io_dmem_resp_valid, io_busy});
    end
    tick();
    io_mem_resp_valid = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_conflict();
    test_backpressure();
    test_timeout();
    test_reset_mid_wait();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d responses outstanding, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
